bullet_trajectory: RTL and testbench

- Per-tank projectile engine, directly upstream of the frame-time counter.
- Launches a shell on `fire` and asserts `drawbullflag` while the shell is live; the time counter runs off that flag.
- Consumes the counter's `time_in` and computes the ballistic `bullet_x`/`bullet_y` once per frame.
- Detects side-wall bounces (`xbound`), ground impact and target hits; terminates the shot.

---
 rtl/tank_pkg.sv | 41 ++++
 rtl/traj_calc.sv | 42 ++++
 rtl/bullet_trajectory.sv | 184 ++++++++++++++++++
 tb/tb_bullet_trajectory.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared types and constants for the tank projectile engine.
package tank_pkg;

  localparam int unsigned TW         = 10;
  localparam int unsigned PW         = 12;
  localparam int unsigned CW         = 10;
  localparam int unsigned VW         = 3;
  localparam int unsigned BW         = 2;
  localparam int unsigned GSHIFT     = 1;
  localparam int unsigned MAX_BOUNCE = 2;

  localparam logic signed [PW-1:0] LEFT_X   = PW'(10);
  localparam logic signed [PW-1:0] RIGHT_X  = PW'(630);
  localparam logic signed [PW-1:0] GROUND_Y = PW'(440);
  localparam logic signed [PW-1:0] HIT_R    = PW'(8);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_FLIGHT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [VW-1:0] vx;
    logic [VW-1:0] vy;
  } vel_t;

  // Launch velocity per angle selection: shallow to steep.
  function automatic vel_t vel_lookup(input logic [1:0] sel);
    vel_t v;
    case (sel)
      2'd0:    begin v.vx = VW'(4); v.vy = VW'(2); end
      2'd1:    begin v.vx = VW'(3); v.vy = VW'(3); end
      2'd2:    begin v.vx = VW'(2); v.vy = VW'(4); end
      default: begin v.vx = VW'(1); v.vy = VW'(5); end
    endcase
    return v;
  endfunction

endpackage

// File: rtl/traj_calc.sv
// Combinational ballistic position from launch point, velocity and time.
module traj_calc
  import tank_pkg::*;
(
  input  logic signed [PW-1:0] i_x0,
  input  logic signed [PW-1:0] i_y0,
  input  logic        [VW-1:0] i_vx,
  input  logic        [VW-1:0] i_vy,
  input  logic                 i_dir_left,
  input  logic        [TW-1:0] i_t,
  input  logic        [TW-1:0] i_t_base,
  output logic signed [PW-1:0] o_xc,
  output logic signed [PW-1:0] o_yc
);

  logic signed [PW-1:0] w_t;
  logic signed [PW-1:0] w_tb;
  logic signed [PW-1:0] w_dt;
  logic signed [PW-1:0] w_vx;
  logic signed [PW-1:0] w_vy;
  logic signed [PW-1:0] w_dx;
  logic signed [PW-1:0] w_sq;
  logic signed [PW-1:0] w_gy;

  // Horizontal travel since the last bounce; vertical from launch with gravity.
  always_comb begin
    w_t  = PW'(i_t);
    w_tb = PW'(i_t_base);
    w_vx = PW'(i_vx);
    w_vy = PW'(i_vy);
    w_dt = w_t - w_tb;
    if (w_dt < 0) begin
      w_dt = '0;
    end
    w_dx = w_vx * w_dt;
    w_sq = w_t * w_t;
    w_gy = w_sq >>> GSHIFT;
    o_xc = i_dir_left ? (i_x0 - w_dx) : (i_x0 + w_dx);
    o_yc = i_y0 - (w_vy * w_t) + w_gy;
  end

endmodule

// File: rtl/bullet_trajectory.sv
// Per-tank shell launcher: flight state, wall bounces, ground and target hits.
module bullet_trajectory
  import tank_pkg::*;
(
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic          fire,
  input  logic [CW-1:0] tank_x,
  input  logic [CW-1:0] tank_y,
  input  logic          facing_left,
  input  logic [1:0]    angle_sel,
  input  logic [CW-1:0] target_x,
  input  logic [CW-1:0] target_y,
  input  logic [63:0]   time_in,
  output logic          drawbullflag,
  output logic          xbound,
  output logic [CW-1:0] bullet_x,
  output logic [CW-1:0] bullet_y,
  output logic          hit
);

  state_t               r_state, w_state_nxt;
  logic signed [PW-1:0] r_x0, w_x0_nxt;
  logic signed [PW-1:0] r_y0, w_y0_nxt;
  logic        [VW-1:0] r_vx, w_vx_nxt;
  logic        [VW-1:0] r_vy, w_vy_nxt;
  logic                 r_dir_left, w_dir_left_nxt;
  logic        [TW-1:0] r_t_base, w_t_base_nxt;
  logic        [BW-1:0] r_bounce_cnt, w_bounce_cnt_nxt;
  logic                 r_draw, w_draw_nxt;
  logic                 r_xbound, w_xbound_nxt;
  logic                 r_hit, w_hit_nxt;
  logic        [CW-1:0] r_bx, w_bx_nxt;
  logic        [CW-1:0] r_by, w_by_nxt;

  logic        [TW-1:0]    w_t;
  logic        [63-TW:0]   w_unused_time;
  logic signed [PW-1:0]    w_xc;
  logic signed [PW-1:0]    w_yc;
  logic signed [PW-1:0]    w_ex;
  logic signed [PW-1:0]    w_ey;
  logic signed [PW-1:0]    w_ax;
  logic signed [PW-1:0]    w_ay;
  logic signed [PW-1:0]    w_wall;
  logic                    w_on_target;
  vel_t                    w_vel;

  assign w_t           = time_in[TW-1:0];
  assign w_unused_time = time_in[63:TW];
  assign w_vel         = vel_lookup(angle_sel);

  traj_calc u_traj_calc (
    .i_x0       (r_x0),
    .i_y0       (r_y0),
    .i_vx       (r_vx),
    .i_vy       (r_vy),
    .i_dir_left (r_dir_left),
    .i_t        (w_t),
    .i_t_base   (r_t_base),
    .o_xc       (w_xc),
    .o_yc       (w_yc)
  );

  // Square hit box test around the opponent's centre.
  always_comb begin
    w_ex        = w_xc - signed'(PW'(target_x));
    w_ey        = w_yc - signed'(PW'(target_y));
    w_ax        = (w_ex < 0) ? -w_ex : w_ex;
    w_ay        = (w_ey < 0) ? -w_ey : w_ey;
    w_on_target = (w_ax <= HIT_R) && (w_ay <= HIT_R);
  end

  // Next-state and next-output logic; one flight action per frame.
  always_comb begin
    w_state_nxt      = r_state;
    w_x0_nxt         = r_x0;
    w_y0_nxt         = r_y0;
    w_vx_nxt         = r_vx;
    w_vy_nxt         = r_vy;
    w_dir_left_nxt   = r_dir_left;
    w_t_base_nxt     = r_t_base;
    w_bounce_cnt_nxt = r_bounce_cnt;
    w_draw_nxt       = 1'b0;
    w_xbound_nxt     = 1'b0;
    w_hit_nxt        = 1'b0;
    w_bx_nxt         = r_bx;
    w_by_nxt         = r_by;
    w_wall           = (w_xc > RIGHT_X) ? RIGHT_X : LEFT_X;

    case (r_state)
      ST_IDLE: begin
        if (fire) begin
          w_x0_nxt         = signed'(PW'(tank_x));
          w_y0_nxt         = signed'(PW'(tank_y));
          w_vx_nxt         = w_vel.vx;
          w_vy_nxt         = w_vel.vy;
          w_dir_left_nxt   = facing_left;
          w_t_base_nxt     = '0;
          w_bounce_cnt_nxt = '0;
          w_draw_nxt       = 1'b1;
          w_bx_nxt         = tank_x;
          w_by_nxt         = tank_y;
          w_state_nxt      = ST_ARM;
        end
      end
      ST_ARM: begin
        w_draw_nxt  = 1'b1;
        w_state_nxt = ST_FLIGHT;
      end
      ST_FLIGHT: begin
        w_draw_nxt = 1'b1;
        w_bx_nxt   = CW'(w_xc);
        w_by_nxt   = (w_yc < 0) ? '0 : CW'(w_yc);
        if (w_on_target) begin
          w_hit_nxt   = 1'b1;
          w_draw_nxt  = 1'b0;
          w_state_nxt = ST_DONE;
        end else if (w_yc >= GROUND_Y) begin
          w_by_nxt    = CW'(GROUND_Y);
          w_draw_nxt  = 1'b0;
          w_state_nxt = ST_DONE;
        end else if ((w_xc > RIGHT_X) || (w_xc < LEFT_X)) begin
          w_bx_nxt = CW'(w_wall);
          if (r_bounce_cnt == BW'(MAX_BOUNCE)) begin
            w_draw_nxt  = 1'b0;
            w_state_nxt = ST_DONE;
          end else begin
            w_x0_nxt         = w_wall;
            w_t_base_nxt     = w_t;
            w_dir_left_nxt   = ~r_dir_left;
            w_bounce_cnt_nxt = r_bounce_cnt + BW'(1);
            w_xbound_nxt     = 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_x0         <= '0;
      r_y0         <= '0;
      r_vx         <= '0;
      r_vy         <= '0;
      r_dir_left   <= 1'b0;
      r_t_base     <= '0;
      r_bounce_cnt <= '0;
      r_draw       <= 1'b0;
      r_xbound     <= 1'b0;
      r_hit        <= 1'b0;
      r_bx         <= '0;
      r_by         <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_x0         <= w_x0_nxt;
      r_y0         <= w_y0_nxt;
      r_vx         <= w_vx_nxt;
      r_vy         <= w_vy_nxt;
      r_dir_left   <= w_dir_left_nxt;
      r_t_base     <= w_t_base_nxt;
      r_bounce_cnt <= w_bounce_cnt_nxt;
      r_draw       <= w_draw_nxt;
      r_xbound     <= w_xbound_nxt;
      r_hit        <= w_hit_nxt;
      r_bx         <= w_bx_nxt;
      r_by         <= w_by_nxt;
    end
  end

  assign drawbullflag = r_draw;
  assign xbound       = r_xbound;
  assign hit          = r_hit;
  assign bullet_x     = r_bx;
  assign bullet_y     = r_by;

endmodule

// File: tb/tb_bullet_trajectory.sv
// Directed vector bench for the shell trajectory engine.
module tb_bullet_trajectory;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        fire;
  logic [9:0]  tank_x;
  logic [9:0]  tank_y;
  logic        facing_left;
  logic [1:0]  angle_sel;
  logic [9:0]  target_x;
  logic [9:0]  target_y;
  logic [63:0] time_in;
  logic        drawbullflag;
  logic        xbound;
  logic [9:0]  bullet_x;
  logic [9:0]  bullet_y;
  logic        hit;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [9:0] FX = 10'd900;
  localparam logic [9:0] FY = 10'd50;

  always #5 frame_clk = ~frame_clk;

  bullet_trajectory dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .fire         (fire),
    .tank_x       (tank_x),
    .tank_y       (tank_y),
    .facing_left  (facing_left),
    .angle_sel    (angle_sel),
    .target_x     (target_x),
    .target_y     (target_y),
    .time_in      (time_in),
    .drawbullflag (drawbullflag),
    .xbound       (xbound),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .hit          (hit)
  );

  typedef struct {
    logic        rst;
    logic        fire;
    logic [9:0]  tx;
    logic [9:0]  ty;
    logic        left;
    logic [1:0]  ang;
    logic [9:0]  gx;
    logic [9:0]  gy;
    logic [63:0] t;
    logic        e_draw;
    logic        e_xb;
    logic        e_hit;
    logic [9:0]  e_bx;
    logic [9:0]  e_by;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic f, input logic [9:0] tx, input logic [9:0] ty,
                     input logic left, input logic [1:0] ang, input logic [9:0] gx,
                     input logic [9:0] gy, input logic [63:0] t, input logic e_draw,
                     input logic e_xb, input logic e_hit, input logic [9:0] e_bx,
                     input logic [9:0] e_by);
    vec_t v;
    v.rst = rst; v.fire = f; v.tx = tx; v.ty = ty; v.left = left; v.ang = ang;
    v.gx = gx; v.gy = gy; v.t = t; v.e_draw = e_draw; v.e_xb = e_xb; v.e_hit = e_hit;
    v.e_bx = e_bx; v.e_by = e_by;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    Reset = v.rst; fire = v.fire; tank_x = v.tx; tank_y = v.ty; facing_left = v.left;
    angle_sel = v.ang; target_x = v.gx; target_y = v.gy; time_in = v.t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  hits;
    int  xbs;
    bit  dropped;
    bit  seen_live;
    bit  relaunched;

    Reset = 1'b1; fire = 1'b0; tank_x = '0; tank_y = '0; facing_left = 1'b0;
    angle_sel = '0; target_x = FX; target_y = FY; time_in = '0;

    //   rst f   tx    ty   lf ang gx    gy     t     drw xb hit bx   by
    // Shot 1: (100,400) angle 1 right, ends on the ground.
    add(1, 0,   0,    0, 0, 0, FX,   FY,   0,    0, 0, 0,   0,   0);
    add(0, 1, 100,  400, 0, 1, FX,   FY,   0,    1, 0, 0, 100, 400);
    add(0, 1, 100,  400, 0, 1, FX,   FY,   0,    1, 0, 0, 100, 400);
    add(0, 1, 100,  400, 0, 1, FX,   FY,   0,    1, 0, 0, 100, 400);
    add(0, 1, 100,  400, 0, 1, FX,   FY,   1,    1, 0, 0, 103, 397);
    add(0, 1, 100,  400, 0, 1, FX,   FY,   64'hFFFF_0000_0000_0002, 1, 0, 0, 106, 396);
    add(0, 1, 100,  400, 0, 1, FX,   FY,   6,    1, 0, 0, 118, 400);
    add(0, 1, 100,  400, 0, 1, FX,   FY,   7,    1, 0, 0, 121, 403);
    add(0, 1, 100,  400, 0, 1, FX,   FY,  12,    1, 0, 0, 136, 436);
    add(0, 1, 100,  400, 0, 1, FX,   FY,  13,    0, 0, 0, 139, 440);
    add(0, 1, 100,  400, 0, 1, FX,   FY,   0,    0, 0, 0, 139, 440);
    add(0, 0, 100,  400, 0, 1, FX,   FY,   0,    0, 0, 0, 139, 440);
    // Shot 2: (620,100) angle 0 right, bounces off the right wall at t=3.
    add(0, 1, 620,  100, 0, 0, FX,   FY,   0,    1, 0, 0, 620, 100);
    add(0, 0, 620,  100, 0, 0, FX,   FY,   0,    1, 0, 0, 620, 100);
    add(0, 0, 620,  100, 0, 0, FX,   FY,   0,    1, 0, 0, 620, 100);
    add(0, 0, 620,  100, 0, 0, FX,   FY,   3,    1, 1, 0, 630,  98);
    add(0, 0, 620,  100, 0, 0, FX,   FY,   4,    1, 0, 0, 626, 100);
    add(0, 0, 620,  100, 0, 0, FX,   FY,   5,    1, 0, 0, 622, 102);
    add(0, 0, 620,  100, 0, 0, FX,   FY,   2,    1, 0, 0, 630,  98);
    // Reset mid-flight, then a new shot launches one frame later.
    add(1, 0, 620,  100, 0, 0, FX,   FY,   2,    0, 0, 0,   0,   0);
    // Shot 3: (12,400) angle 0 left, two bounces then third contact ends it.
    add(0, 1,  12,  400, 1, 0, FX,   FY,   0,    1, 0, 0,  12, 400);
    add(0, 0,  12,  400, 1, 0, FX,   FY,   0,    1, 0, 0,  12, 400);
    add(0, 0,  12,  400, 1, 0, FX,   FY,   0,    1, 0, 0,  12, 400);
    add(0, 0,  12,  400, 1, 0, FX,   FY,   1,    1, 1, 0,  10, 398);
    add(0, 0,  12,  400, 1, 0, FX,   FY,   2,    1, 0, 0,  14, 398);
    add(0, 0,  12,  400, 1, 0, FX,   FY, 157,    1, 1, 0, 630, 122);
    add(0, 0,  12,  400, 1, 0, FX,   FY, 158,    1, 0, 0, 626, 278);
    add(0, 0,  12,  400, 1, 0, FX,   FY, 313,    0, 0, 0,  10,   0);
    add(0, 0,  12,  400, 1, 0, FX,   FY,   0,    0, 0, 0,  10,   0);
    add(0, 0,  12,  400, 1, 0, FX,   FY,   0,    0, 0, 0,  10,   0);
    // Shot 4: target at (106,396) with fire held throughout.
    add(0, 1, 100,  400, 0, 1, 106, 396,   0,    1, 0, 0, 100, 400);
    add(0, 1, 100,  400, 0, 1, 106, 396,   0,    1, 0, 0, 100, 400);
    add(0, 1, 100,  400, 0, 1, 106, 396,   2,    0, 0, 1, 106, 396);
    add(0, 1, 100,  400, 0, 1, 106, 396,   0,    0, 0, 0, 106, 396);
    add(0, 1, 100,  400, 0, 1, 106, 396,   0,    1, 0, 0, 100, 400);
    // Shot 5: (300,5) angle 3 right, rises above the top edge and keeps flying.
    add(1, 0,   0,    0, 0, 0, FX,   FY,   0,    0, 0, 0,   0,   0);
    add(0, 1, 300,    5, 0, 3, FX,   FY,   0,    1, 0, 0, 300,   5);
    add(0, 0, 300,    5, 0, 3, FX,   FY,   0,    1, 0, 0, 300,   5);
    add(0, 0, 300,    5, 0, 3, FX,   FY,   2,    1, 0, 0, 302,   0);
    add(0, 0, 300,    5, 0, 3, FX,   FY,   3,    1, 0, 0, 303,   0);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge frame_clk);
      #1;
      check($sformatf("v%0d drawbullflag", i), 32'(drawbullflag), 32'(vecs[i].e_draw));
      check($sformatf("v%0d xbound", i),       32'(xbound),       32'(vecs[i].e_xb));
      check($sformatf("v%0d hit", i),          32'(hit),          32'(vecs[i].e_hit));
      check($sformatf("v%0d bullet_x", i),     32'(bullet_x),     32'(vecs[i].e_bx));
      check($sformatf("v%0d bullet_y", i),     32'(bullet_y),     32'(vecs[i].e_by));
    end

    // Free-running shot with a modelled time counter and fire held high.
    Reset = 1'b1; fire = 1'b0; time_in = '0;
    @(posedge frame_clk); #1;
    Reset = 1'b0; fire = 1'b1; tank_x = 10'd100; tank_y = 10'd400;
    facing_left = 1'b0; angle_sel = 2'd1; target_x = FX; target_y = FY;
    hits = 0; xbs = 0; dropped = 1'b0; seen_live = 1'b0;
    for (int c = 0; c < 60 && !dropped; c++) begin
      @(posedge frame_clk); #1;
      if (hit) hits++;
      if (xbound) xbs++;
      check($sformatf("run c%0d xbound&hit", c), 32'(xbound & hit), 32'(0));
      if (drawbullflag) seen_live = 1'b1;
      else if (seen_live) dropped = 1'b1;
      time_in = drawbullflag ? time_in + 64'd1 : 64'd0;
    end
    check("run flag dropped", 32'(dropped), 32'(1));
    check("run landing y", 32'(bullet_y), 32'(440));
    check("run hit pulses", 32'(hits), 32'(0));
    check("run xbound pulses", 32'(xbs), 32'(0));
    relaunched = 1'b0;
    for (int c = 0; c < 4 && !relaunched; c++) begin
      @(posedge frame_clk); #1;
      if (drawbullflag) relaunched = 1'b1;
    end
    check("run relaunch after idle", 32'(relaunched), 32'(1));
    check("run relaunch x", 32'(bullet_x), 32'(100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
